// File: rtl/pushbutton_controller.sv
// Avalon-MM pushbutton controller: synchronizes and debounces the raw buttons, then
// exposes debounced state, sticky press flags, an interrupt mask and a press counter.
module pushbutton_controller #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             address,
  input  logic                   chipselect,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  input  logic [NUM_BUTTONS-1:0] pushbuttons,
  output logic [31:0]            readdata,
  output logic                   irq
);

  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PCW = $clog2(NUM_BUTTONS + 1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] RELEASED = ACTIVE_LOW ? '1 : '0;

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  logic [NUM_BUTTONS-1:0] r_syncMeta;
  logic [NUM_BUTTONS-1:0] r_syncOut;
  logic [NUM_BUTTONS-1:0] r_state;
  logic [NUM_BUTTONS-1:0] r_edge;
  logic [NUM_BUTTONS-1:0] r_mask;
  logic [CW-1:0]          r_cnt [NUM_BUTTONS];
  logic [15:0]            r_count;

  logic [NUM_BUTTONS-1:0] w_synced;
  logic [NUM_BUTTONS-1:0] w_mismatch;
  logic [NUM_BUTTONS-1:0] w_toggle;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [PCW-1:0]         w_pressCount;
  logic                   w_wrEn;
  logic                   w_rdEn;
  logic [NUM_BUTTONS-1:0] w_edgeClr;
  logic [NUM_BUTTONS-1:0] w_edgeNext;
  logic [NUM_BUTTONS-1:0] w_maskNext;
  logic [16:0]            w_countSum;
  logic [15:0]            w_countNext;
  logic [31:0]            w_readMux;
  logic                   w_unusedWdata;

  // Synchronizer flops idle at the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_syncMeta <= RELEASED;
      r_syncOut  <= RELEASED;
    end else begin
      r_syncMeta <= pushbuttons;
      r_syncOut  <= r_syncMeta;
    end
  end

  assign w_synced = ACTIVE_LOW ? ~r_syncOut : r_syncOut;

  always_comb begin
    w_mismatch = '0;
    w_toggle   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_mismatch[i] = w_synced[i] ^ r_state[i];
      w_toggle[i]   = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= r_state ^ w_toggle;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (!w_mismatch[i] || w_toggle[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = w_toggle & ~r_state;

  always_comb begin
    w_pressCount = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_pressCount = w_pressCount + PCW'(w_press[i]);
    end
  end

  assign w_wrEn = chipselect & write;
  assign w_rdEn = chipselect & read;

  assign w_edgeClr  = (w_wrEn && address == ADDR_EDGE) ? writedata[NUM_BUTTONS-1:0] : '0;
  assign w_edgeNext = (r_edge & ~w_edgeClr) | w_press;
  assign w_maskNext = (w_wrEn && address == ADDR_MASK) ? writedata[NUM_BUTTONS-1:0] : r_mask;

  // A clear racing a press keeps the new presses rather than dropping them.
  assign w_countSum = 17'(r_count) + 17'(w_pressCount);
  always_comb begin
    w_countNext = r_count;
    if (w_wrEn && address == ADDR_COUNT) begin
      w_countNext = 16'(w_pressCount);
    end else if (w_countSum[16]) begin
      w_countNext = 16'hFFFF;
    end else begin
      w_countNext = w_countSum[15:0];
    end
  end

  always_comb begin
    w_readMux = '0;
    case (address)
      ADDR_STATE: w_readMux = 32'(r_state);
      ADDR_EDGE:  w_readMux = 32'(r_edge);
      ADDR_MASK:  w_readMux = 32'(r_mask);
      ADDR_COUNT: w_readMux = 32'(r_count);
      default:    w_readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge   <= '0;
      r_mask   <= '0;
      r_count  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      r_edge  <= w_edgeNext;
      r_mask  <= w_maskNext;
      r_count <= w_countNext;
      if (w_rdEn) begin
        readdata <= w_readMux;
      end
      irq <= |(w_edgeNext & w_maskNext);
    end
  end

  assign w_unusedWdata = ^writedata[31:NUM_BUTTONS];

endmodule

// File: tb/tb_pushbutton_controller.sv
// Bench for pushbutton_controller: directed vector table, corner sequences, randomized
// traffic against a history-based reference model, and counter saturation on a 16-button copy.
module tb_pushbutton_controller;

  localparam int NB  = 4;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  pushbuttons;
  logic [31:0] readdata;
  logic        irq;

  logic        satReset;
  logic [1:0]  satAddress;
  logic        satCs;
  logic        satRd;
  logic        satWr;
  logic [31:0] satWdata;
  logic [15:0] satPb;
  logic [31:0] satReaddata;
  logic        satIrq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pushbutton_controller #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
    .write(write), .writedata(writedata), .pushbuttons(pushbuttons), .readdata(readdata),
    .irq(irq)
  );

  pushbutton_controller #(.NUM_BUTTONS(16), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) satDut (
    .clk(clk), .reset(satReset), .address(satAddress), .chipselect(satCs), .read(satRd),
    .write(satWr), .writedata(satWdata), .pushbuttons(satPb), .readdata(satReaddata),
    .irq(satIrq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button flips once its last DEB synchronized samples all disagree with it.
  logic [3:0]  rawQ [$];
  logic [3:0]  synQ [$];
  logic [3:0]  mState, mEdge, mMask, mNext, mPressed, mClr, mSynced;
  logic [15:0] mCount;
  logic [31:0] mRead;
  logic        mIrq;
  logic        mAll;
  int          mSum;
  bit          modelValid = 0;

  always @(posedge clk) begin
    if (reset) begin
      mState = '0; mEdge = '0; mMask = '0; mCount = '0; mRead = '0; mIrq = 1'b0;
      rawQ = '{4'h0, 4'h0};
      synQ.delete();
      modelValid = 1;
    end else if (modelValid) begin
      rawQ.push_back(~pushbuttons);
      mSynced = rawQ.pop_front();
      synQ.push_back(mSynced);
      if (synQ.size() > DEB) void'(synQ.pop_front());
      mNext = mState;
      if (synQ.size() == DEB) begin
        for (int b = 0; b < NB; b++) begin
          mAll = 1'b1;
          foreach (synQ[j]) if (synQ[j][b] == mState[b]) mAll = 1'b0;
          if (mAll) mNext[b] = ~mState[b];
        end
      end
      mPressed = mNext & ~mState;
      if (chipselect && read) begin
        case (address)
          2'd0: mRead = {28'd0, mState};
          2'd1: mRead = {28'd0, mEdge};
          2'd2: mRead = {28'd0, mMask};
          default: mRead = {16'd0, mCount};
        endcase
      end
      mClr  = (chipselect && write && address == 2'd1) ? writedata[3:0] : 4'h0;
      mEdge = (mEdge & ~mClr) | mPressed;
      if (chipselect && write && address == 2'd2) mMask = writedata[3:0];
      mSum = $countones(mPressed);
      if (chipselect && write && address == 2'd3) mCount = 16'(mSum);
      else if (int'(mCount) + mSum > 65535) mCount = 16'hFFFF;
      else mCount = 16'(int'(mCount) + mSum);
      mState = mNext;
      mIrq   = |(mEdge & mMask);
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model readdata", readdata, mRead);
      checkOutput("model irq", {31'd0, irq}, {31'd0, mIrq});
    end
  end

  task automatic applyStimulus(input logic rst, input logic [1:0] a, input logic rd,
                               input logic wr, input logic [31:0] wd, input logic [3:0] pb);
    reset = rst; address = a; chipselect = rd | wr; read = rd; write = wr;
    writedata = wd; pushbuttons = pb;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [3:0] pb);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, pb);
  endtask

  task automatic readReg(input string name, input logic [1:0] a, input logic [3:0] pb,
                         input logic [31:0] exp);
    applyStimulus(1'b0, a, 1'b1, 1'b0, 32'd0, pb);
    checkOutput(name, readdata, exp);
  endtask

  task automatic satStep(input logic [15:0] pb, input logic rd);
    satPb = pb; satRd = rd; satCs = rd; satAddress = 2'd3;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  pb;
    logic [31:0] expRead;
    logic        expIrq;
  } vec_t;

  vec_t vecs [20];
  int   hold;
  int   expSat;
  logic [3:0] rndPb;

  initial begin
    vecs[0]  = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0, 1'b0};
    vecs[1]  = '{2'd1, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0, 1'b0};
    vecs[2]  = '{2'd2, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0, 1'b0};
    vecs[3]  = '{2'd3, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0, 1'b0};
    vecs[4]  = '{2'd2, 1'b0, 1'b1, 32'd1, 4'hE, 32'd0, 1'b0};
    vecs[5]  = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b0};
    vecs[6]  = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b0};
    vecs[7]  = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b0};
    vecs[8]  = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b0};
    vecs[9]  = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b1};
    vecs[10] = '{2'd0, 1'b1, 1'b0, 32'd0, 4'hE, 32'd1, 1'b1};
    vecs[11] = '{2'd1, 1'b1, 1'b0, 32'd0, 4'hE, 32'd1, 1'b1};
    vecs[12] = '{2'd3, 1'b1, 1'b0, 32'd0, 4'hE, 32'd1, 1'b1};
    vecs[13] = '{2'd2, 1'b1, 1'b0, 32'd0, 4'hE, 32'd1, 1'b1};
    vecs[14] = '{2'd1, 1'b1, 1'b1, 32'd2, 4'hE, 32'd1, 1'b1};
    vecs[15] = '{2'd1, 1'b1, 1'b0, 32'd0, 4'hE, 32'd1, 1'b1};
    vecs[16] = '{2'd1, 1'b1, 1'b1, 32'd1, 4'hE, 32'd1, 1'b0};
    vecs[17] = '{2'd1, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b0};
    vecs[18] = '{2'd3, 1'b0, 1'b1, 32'd0, 4'hE, 32'd0, 1'b0};
    vecs[19] = '{2'd3, 1'b1, 1'b0, 32'd0, 4'hE, 32'd0, 1'b0};

    reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; pushbuttons = 4'hF;
    satReset = 1'b1; satAddress = 2'd3; satCs = 1'b0; satRd = 1'b0; satWr = 1'b0;
    satWdata = '0; satPb = 16'hFFFF;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].pb);
      checkOutput($sformatf("vec%0d readdata", i), readdata, vecs[i].expRead);
      checkOutput($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].expIrq});
    end

    // Three-cycle glitch on bit1 must be rejected.
    idle(3, 4'hC);
    idle(10, 4'hE);
    readReg("glitch state", 2'd0, 4'hE, 32'h1);
    readReg("glitch edge", 2'd1, 4'hE, 32'h0);
    readReg("glitch count", 2'd3, 4'hE, 32'h0);

    // Two buttons pressed on the same cycle count twice.
    idle(10, 4'h2);
    readReg("dual count", 2'd3, 4'h2, 32'h2);
    readReg("dual edge", 2'd1, 4'h2, 32'hC);

    // Count clear landing on the same edge as a press keeps that press.
    idle(10, 4'hF);
    idle(5, 4'hE);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b1, 32'd0, 4'hE);
    readReg("clear+press count", 2'd3, 4'hE, 32'h1);

    // Reset in the middle of a debounce discards it; a held press then restarts from zero.
    idle(10, 4'hF);
    idle(4, 4'hE);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 4'hE);
    checkOutput("reset readdata", readdata, 32'h0);
    checkOutput("reset irq", {31'd0, irq}, 32'h0);
    readReg("post-reset edge", 2'd1, 4'hE, 32'h0);
    readReg("post-reset mask", 2'd2, 4'hE, 32'h0);
    readReg("post-reset count", 2'd3, 4'hE, 32'h0);
    readReg("post-reset state t4", 2'd0, 4'hE, 32'h0);
    readReg("post-reset state t5", 2'd0, 4'hE, 32'h0);
    readReg("post-reset state t6", 2'd0, 4'hE, 32'h0);
    readReg("post-reset state t7", 2'd0, 4'hE, 32'h1);

    // Randomized traffic; every cycle is scored against the model.
    hold = 0;
    rndPb = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        rndPb = 4'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      reset       = ($urandom_range(0, 299) == 0);
      chipselect  = ($urandom_range(0, 3) != 0);
      read        = 1'($urandom);
      write       = ($urandom_range(0, 3) == 0);
      address     = 2'($urandom);
      writedata   = $urandom;
      pushbuttons = rndPb;
      @(negedge clk);
    end
    idle(1, 4'hF);

    // Saturation: every period presses all 16 buttons once.
    satReset = 1'b0;
    for (int p = 1; p <= 4100; p++) begin
      for (int k = 0; k < 6; k++) satStep(16'h0000, 1'b0);
      for (int k = 0; k < 6; k++) satStep(16'hFFFF, 1'b0);
      if (p == 100 || p == 4095 || p == 4096 || p == 4100) begin
        satStep(16'hFFFF, 1'b1);
        expSat = (16 * p > 65535) ? 65535 : 16 * p;
        checkOutput($sformatf("sat count p%0d", p), satReaddata, 32'(expSat));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
